// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port scheduler with burst locking.
// Sits in front of the asynchronous command FIFO write interface and shares
// its single write port between NUM_REQ requesters. A grant holds the port
// for up to MAX_BURST beats or until the requester flags its last beat.
// Optional build macro ARB_TIMEOUT_EN: releases a lock after IDLE_TIMEOUT
// consecutive cycles without a valid beat from the holder and adds the
// timeout_evt pulse output.
module fifo_wr_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int DATA_WIDTH   = 41,
   parameter int MAX_BURST    = 4,
   parameter int IDLE_TIMEOUT = 16,
   localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          wr_clk,
   input  logic                          wr_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy
`ifdef ARB_TIMEOUT_EN
   ,
   output logic                          timeout_evt
`endif
);

   localparam int BW = $clog2(MAX_BURST) + 1;

   // Out-of-range configurations are rejected at elaboration.
   if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16 || IDLE_TIMEOUT < 1) begin : g_param_check
      $error("fifo_wr_arbiter: parameter out of range");
   end

   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t          state_reg, state_next;
   logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
   logic [GW-1:0]   grant_id_reg, grant_id_next;
   logic [GW-1:0]   last_grant_reg, last_grant_next;
   logic [GW-1:0]   scan_idx, sel_idx;
   logic            sel_found;
   logic            accept;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

`ifdef ARB_TIMEOUT_EN
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);
   logic [TW-1:0]   idle_cnt_reg, idle_cnt_next;
`endif

   // Unpack the flat data bus; the write data simply follows the grant.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = accept && (grant_id_reg == GW'(gi));
   end

   assign fifo_wr_data = data_arr[grant_id_reg];
   assign busy         = (state_reg == BURST);
   assign grant_id     = grant_id_reg;
   assign accept       = busy && req_valid[grant_id_reg] && !fifo_full;
   assign fifo_wr_en   = accept;

   // Round-robin pick: first valid requester after the last one served.
   always_comb begin
      scan_idx  = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = GW'((int'(last_grant_reg) + k) % NUM_REQ);
         if (!sel_found && req_valid[scan_idx]) begin
            sel_found = 1'b1;
            sel_idx   = scan_idx;
         end
      end
   end

   // Next-state logic: arbitrate in IDLE, count beats and release in BURST.
   always_comb begin
      state_next      = state_reg;
      beat_cnt_next   = beat_cnt_reg;
      grant_id_next   = grant_id_reg;
      last_grant_next = last_grant_reg;
`ifdef ARB_TIMEOUT_EN
      idle_cnt_next   = '0;
      timeout_evt     = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (sel_found) begin
               grant_id_next   = sel_idx;
               last_grant_next = sel_idx;
               beat_cnt_next   = '0;
               state_next      = BURST;
            end
         end
         BURST: begin
            if (accept) begin
               if (req_last[grant_id_reg] || beat_cnt_reg == BW'(MAX_BURST - 1)) begin
                  beat_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  beat_cnt_next = beat_cnt_reg + 1'b1;
               end
            end
`ifdef ARB_TIMEOUT_EN
            // Only cycles with the holder's valid low count toward release.
            if (!req_valid[grant_id_reg]) begin
               if (idle_cnt_reg == TW'(IDLE_TIMEOUT - 1)) begin
                  timeout_evt   = 1'b1;
                  beat_cnt_next = '0;
                  state_next    = IDLE;
               end else begin
                  idle_cnt_next = idle_cnt_reg + 1'b1;
               end
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // State registers; reset makes requester 0 the first winner.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state_reg      <= IDLE;
         beat_cnt_reg   <= '0;
         grant_id_reg   <= '0;
         last_grant_reg <= GW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
         idle_cnt_reg   <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         beat_cnt_reg   <= beat_cnt_next;
         grant_id_reg   <= grant_id_next;
         last_grant_reg <= last_grant_next;
`ifdef ARB_TIMEOUT_EN
         idle_cnt_reg   <= idle_cnt_next;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: per-cycle vector table plus hand sequences.
// Each requester's data word is {id, beat sequence number}, so every accepted
// beat must carry the next unused number of the granted requester.
module tb_fifo_wr_arbiter;
   localparam int NR = 2;
   localparam int DW = 41;
   localparam int MB = 4;
   localparam int TO = 16;

   logic               wr_clk = 1'b0;
   logic               wr_rst = 1'b1;
   logic [NR-1:0]      req_valid = '0;
   logic [NR*DW-1:0]   req_data = '0;
   logic [NR-1:0]      req_last = '0;
   logic [NR-1:0]      req_ready;
   logic               fifo_full = 1'b0;
   logic               fifo_wr_en;
   logic [DW-1:0]      fifo_wr_data;
   logic [0:0]         grant_id;
   logic               busy;
`ifdef ARB_TIMEOUT_EN
   logic               timeout_evt;
`endif

   fifo_wr_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)
   ) dut (
      .wr_clk(wr_clk), .wr_rst(wr_rst),
      .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .grant_id(grant_id), .busy(busy)
`ifdef ARB_TIMEOUT_EN
      , .timeout_evt(timeout_evt)
`endif
   );

   always #5 wr_clk = ~wr_clk;

   typedef struct {
      logic       rst;
      logic [1:0] valid;
      logic [1:0] last;
      logic       full;
      logic       wr;
      logic [1:0] ready;
      logic       grant;
      logic       busy;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;
   int   writes_seen = 0;
   int   writes_exp = 0;
   int   seq [NR];

   function automatic vec_t v(input logic rst, input logic [1:0] valid, input logic [1:0] last,
                              input logic full, input logic wr, input logic [1:0] ready,
                              input logic grant, input logic bsy);
      vec_t r;
      r.rst = rst; r.valid = valid; r.last = last; r.full = full;
      r.wr = wr; r.ready = ready; r.grant = grant; r.busy = bsy;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check outputs before the rising edge.
   task automatic apply(input int id, input logic rst, input logic [1:0] valid, input logic [1:0] last,
                        input logic full, input logic exp_wr, input logic [1:0] exp_ready,
                        input logic exp_grant, input logic exp_busy, input logic exp_evt);
      logic [DW-1:0] exp_data;
      @(negedge wr_clk);
      wr_rst    = rst;
      req_valid = valid;
      req_last  = last;
      fifo_full = full;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {8'(i), 33'(seq[i])};
      #2;
      check($sformatf("c%0d wr_en", id), 64'(fifo_wr_en), 64'(exp_wr));
      check($sformatf("c%0d req_ready", id), 64'(req_ready), 64'(exp_ready));
      check($sformatf("c%0d grant_id", id), 64'(grant_id), 64'(exp_grant));
      check($sformatf("c%0d busy", id), 64'(busy), 64'(exp_busy));
      if (exp_wr) begin
         exp_data = {8'(exp_grant), 33'(seq[exp_grant])};
         check($sformatf("c%0d wr_data", id), 64'(fifo_wr_data), 64'(exp_data));
      end
`ifdef ARB_TIMEOUT_EN
      check($sformatf("c%0d timeout_evt", id), 64'(timeout_evt), 64'(exp_evt));
`else
      if (exp_evt) check($sformatf("c%0d timeout_evt", id), 64'(0), 64'(1));
`endif
      if (fifo_wr_en) writes_seen++;
      if (exp_wr) writes_exp++;
      for (int i = 0; i < NR; i++) if (exp_ready[i]) seq[i]++;
      $display("cycle %0d: rst=%b valid=%b last=%b full=%b -> wr_en=%b ready=%b grant=%0d busy=%b data=%h",
               id, rst, valid, last, full, fifo_wr_en, req_ready, grant_id, busy, fifo_wr_data);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) seq[i] = 0;

      // rst, valid, last, full | wr, ready, grant, busy
      vecs.push_back(v(1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0)); // reset state
      // single requester, 3 beats
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b01, 2'b01, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));
      // round robin with single-beat bursts
      vecs.push_back(v(0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 2'b11, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b11, 2'b11, 0, 0, 2'b00, 1, 0));
      vecs.push_back(v(0, 2'b11, 2'b11, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b11, 2'b11, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 2'b11, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0));
      // burst cap: req1 6 beats, req0 waits
      vecs.push_back(v(0, 2'b10, 2'b00, 0, 0, 2'b00, 1, 0));
      vecs.push_back(v(0, 2'b11, 2'b00, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b11, 2'b00, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b11, 2'b00, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b11, 2'b00, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b11, 2'b00, 0, 0, 2'b00, 1, 0));
      vecs.push_back(v(0, 2'b11, 2'b01, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b10, 2'b00, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b10, 2'b10, 0, 1, 2'b10, 1, 1));
      vecs.push_back(v(0, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0));
      // full backpressure for 5 cycles mid-burst
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 0, 2'b00, 1, 0));
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1));
      for (int i = 0; i < 5; i++) vecs.push_back(v(0, 2'b01, 2'b00, 1, 0, 2'b00, 0, 1));
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b01, 2'b01, 0, 1, 2'b01, 0, 1));
      // reset after 2 beats; req0 must then beat req1
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(1, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0));
      vecs.push_back(v(0, 2'b11, 2'b01, 0, 1, 2'b01, 0, 1));
      vecs.push_back(v(0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0));

      foreach (vecs[i])
         apply(i, vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].full,
               vecs[i].wr, vecs[i].ready, vecs[i].grant, vecs[i].busy, 1'b0);

      // Gap in a burst: req1 keeps the lock while its valid drops and req0 waits.
      apply(200, 0, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 0);
      apply(201, 0, 2'b10, 2'b00, 0, 1, 2'b10, 1, 1, 0);
      apply(202, 0, 2'b01, 2'b00, 0, 0, 2'b00, 1, 1, 0);
      apply(203, 0, 2'b01, 2'b00, 0, 0, 2'b00, 1, 1, 0);
      apply(204, 0, 2'b01, 2'b00, 1, 0, 2'b00, 1, 1, 0);
      apply(205, 0, 2'b11, 2'b10, 0, 1, 2'b10, 1, 1, 0);
      apply(206, 0, 2'b01, 2'b00, 0, 0, 2'b00, 1, 0, 0);
      apply(207, 0, 2'b01, 2'b01, 0, 1, 2'b01, 0, 1, 0);
      apply(208, 0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0);

`ifdef ARB_TIMEOUT_EN
      // Forced release: req0 goes silent, pulse on the 16th idle cycle, req1 next.
      apply(300, 0, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 0);
      apply(301, 0, 2'b01, 2'b00, 0, 1, 2'b01, 0, 1, 0);
      for (int k = 1; k <= TO; k++)
         apply(301 + k, 0, 2'b10, 2'b00, 0, 0, 2'b00, 0, 1, (k == TO));
      apply(400, 0, 2'b10, 2'b00, 0, 0, 2'b00, 0, 0, 0);
      apply(401, 0, 2'b10, 2'b10, 0, 1, 2'b10, 1, 1, 0);
      apply(402, 0, 2'b00, 2'b00, 0, 0, 2'b00, 1, 0, 0);
`endif

      // Scoreboard: no beat lost or duplicated across the whole run.
      check("total_writes", 64'(writes_seen), 64'(writes_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for the bridge's asynchronous command FIFO.
- Shares the single FIFO write port between NUM_REQ requesters, e.g. the AHB-Lite write path and the AHB-Lite read-request path.
- Round-robin arbitration with burst locking: a granted requester keeps the port for up to MAX_BURST beats, or until it marks its last beat.
- Lives entirely in the write clock domain, directly in front of the FIFO write interface.

Parameters:
- NUM_REQ, 2: number of requesters, range 2..8.
- DATA_WIDTH, 41: FIFO entry width; equals the FIFO's DATA_WIDTH.
- MAX_BURST, 4: maximum beats per grant, range 1..16.
- IDLE_TIMEOUT, 16: cycles of requester inactivity before forced release. Used only with ARB_TIMEOUT_EN.

Ports:
- wr_clk, input, 1: write-domain clock.
- wr_rst, input, 1: write-domain reset, asynchronous, active-high.
- req_valid, input, NUM_REQ: per-requester beat valid.
- req_data, input, NUM_REQ*DATA_WIDTH: per-requester beat data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last, input, NUM_REQ: per-requester last-beat marker, qualified by req_valid.
- req_ready, output, NUM_REQ: per-requester beat accepted this cycle.
- fifo_full, input, 1: FIFO full flag.
- fifo_wr_en, output, 1: FIFO write enable.
- fifo_wr_data, output, DATA_WIDTH: FIFO write data.
- grant_id, output, max(1,$clog2(NUM_REQ)): index of the currently or last granted requester.
- busy, output, 1: high while in BURST.

Behaviour:
- Reset (async, wr_rst=1):
  - state=IDLE, beat_cnt=0, grant_id=0, busy=0.
  - last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
  - req_ready=0, fifo_wr_en=0.
- States: IDLE, BURST.
- IDLE:
  - If any req_valid is high, select the first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Register the selection into grant_id and last_grant; clear beat_cnt; go to BURST.
  - Otherwise stay in IDLE. No beat is transferred in IDLE, so grant latency is 1 cycle.
- BURST:
  - accept = req_valid[grant_id] & ~fifo_full.
  - fifo_wr_en = accept; req_ready[grant_id] = accept; all other req_ready bits = 0.
  - fifo_wr_data = req_data slice of grant_id, driven combinationally in every state. Content is don't-care when fifo_wr_en=0.
  - On accept: beat_cnt increments. If req_last[grant_id]=1 or beat_cnt==MAX_BURST-1, go to IDLE and clear beat_cnt.
  - If req_valid[grant_id] drops mid-burst, keep the lock and stay in BURST (gaps allowed).
- Full handling: while fifo_full=1, nothing is accepted and beat_cnt holds. The beat is taken on the first cycle fifo_full=0.
- Data integrity: a requester must hold req_data and req_last stable while req_valid=1 and req_ready=0.
- Fairness: after a release, the just-served requester has lowest priority at the next arbitration.
- beat_cnt width: $clog2(MAX_BURST)+1; it never exceeds MAX_BURST-1.
- Simultaneous events:
  - The last beat in BURST and new valids cause BURST->IDLE->BURST, i.e. one idle cycle between grants.
  - A requester asserting req_valid during another's burst waits with no effect on the current burst.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. The partially written burst stays in the FIFO; discarding it is the consumer's responsibility.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter in BURST counts consecutive cycles with req_valid[grant_id]=0 and resets on any valid cycle.
  - When the count reaches IDLE_TIMEOUT, return to IDLE (forced release).
  - A 1-cycle output pulse timeout_evt is added to the ports.
  - Cycles blocked by fifo_full with valid high are not counted.
- Not defined: no counter, no timeout_evt port; the lock holds indefinitely until last or MAX_BURST.

Test Plan:
- Single requester: req0 sends 3 beats with last on beat 3, FIFO not full -> grant on cycle 1; fifo_wr_en high cycles 2-4 with req0 data; back to IDLE at cycle 5; busy=1 for cycles 2-4.
- Round-robin: req0 and req1 continuously valid with 1-beat bursts (last=1) -> grant_id alternates 0,1,0,1; one IDLE cycle between grants.
- Burst cap: MAX_BURST=4; req1 sends 6 beats without last while req0 waits -> req1 gets 4 beats, req0 is granted next, then req1 resumes for its remaining 2 beats.
- Full backpressure: fifo_full=1 for 5 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 during those cycles; beat_cnt holds; the beat is accepted the cycle full deasserts; no beat lost or duplicated (scoreboard compare).
- Reset mid-burst: wr_rst asserted after 2 of 4 beats -> outputs zero immediately; after release, req0 wins the first arbitration.
- ARB_TIMEOUT_EN with IDLE_TIMEOUT=16: granted req0 drops valid -> release after 16 idle cycles; timeout_evt pulses once; req1 is granted next.
